// File: rtl/mirfak_pipeline_ctrl.sv
// Mirfak pipeline sequencer: stage enables/clears, PC source, flush FSM.
// Ports: clk_i/rst_i, wb_*/id_* hazard inputs, stage ctrl + stall counter out.
module mirfak_pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_load_use_i,
  input  logic                   wb_lsu_busy_i,
  input  logic                   wb_redirect_i,
  input  logic                   wb_exception_i,
  input  logic                   wb_mret_i,
  output logic                   pc_enable_o,
  output logic [1:0]             pc_sel_o,
  output logic                   ifid_enable_o,
  output logic                   ifid_clear_o,
  output logic                   idex_enable_o,
  output logic                   idex_clear_o,
  output logic                   exwb_enable_o,
  output logic                   exwb_clear_o,
  output logic                   flushing_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE =
    {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic trap;
  logic stall;

  assign trap  = wb_exception_i | wb_mret_i | wb_redirect_i;
  assign stall = (state_q == RUN) & ~trap
               & (wb_lsu_busy_i | id_load_use_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FLUSH;
      fcnt_q  <= FLUSH_INIT;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (trap) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) state_d = RUN;
      end
      default: state_d = FLUSH;
    endcase
  end

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

  assign stall_count_o = stall_q;

  always_comb begin
    pc_enable_o   = 1'b0;
    pc_sel_o      = 2'd0;
    ifid_enable_o = 1'b0;
    ifid_clear_o  = 1'b0;
    idex_enable_o = 1'b0;
    idex_clear_o  = 1'b0;
    exwb_enable_o = 1'b0;
    exwb_clear_o  = 1'b0;
    flushing_o    = 1'b0;
    if (rst_i) begin
      ifid_clear_o = 1'b1;
      idex_clear_o = 1'b1;
      exwb_clear_o = 1'b1;
      flushing_o   = 1'b1;
    end else if (state_q == FLUSH) begin
      pc_enable_o  = 1'b1;
      ifid_clear_o = 1'b1;
      idex_clear_o = 1'b1;
      exwb_clear_o = 1'b1;
      flushing_o   = 1'b1;
    end else if (trap) begin
      pc_enable_o  = 1'b1;
      ifid_clear_o = 1'b1;
      idex_clear_o = 1'b1;
      exwb_clear_o = 1'b1;
      if (wb_exception_i)  pc_sel_o = 2'd2;
      else if (wb_mret_i)  pc_sel_o = 2'd3;
      else                 pc_sel_o = 2'd1;
    end else if (wb_lsu_busy_i) begin
      // whole pipe holds: all defaults
    end else if (id_load_use_i) begin
      // freeze PC and IF/ID, bubble into EX
      idex_clear_o  = 1'b1;
      exwb_enable_o = 1'b1;
    end else begin
      pc_enable_o   = 1'b1;
      ifid_enable_o = 1'b1;
      idex_enable_o = 1'b1;
      exwb_enable_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_mirfak_pipeline_ctrl.sv
// Randomized + directed bench for mirfak_pipeline_ctrl.
// Reference model tracks flush cycles left and stall count as integers.
module tb_mirfak_pipeline_ctrl;

  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lu, lsu, rd, ex, mr;
  logic pc_enable;
  logic [1:0] pc_sel;
  logic ifid_en, ifid_clr, idex_en, idex_clr;
  logic exwb_en, exwb_clr, flushing;
  logic [CW-1:0] stall_count;

  mirfak_pipeline_ctrl #(
    .FLUSH_CYCLES(FC),
    .STALL_CNT_W (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_load_use_i (lu),
    .wb_lsu_busy_i (lsu),
    .wb_redirect_i (rd),
    .wb_exception_i(ex),
    .wb_mret_i     (mr),
    .pc_enable_o   (pc_enable),
    .pc_sel_o      (pc_sel),
    .ifid_enable_o (ifid_en),
    .ifid_clear_o  (ifid_clr),
    .idex_enable_o (idex_en),
    .idex_clear_o  (idex_clr),
    .exwb_enable_o (exwb_en),
    .exwb_clear_o  (exwb_clr),
    .flushing_o    (flushing),
    .stall_count_o (stall_count)
  );

  wire [9:0] ctrl = {pc_enable, pc_sel, ifid_en, ifid_clr,
                     idex_en, idex_clr, exwb_en, exwb_clr,
                     flushing};

  int errors = 0;
  int checks = 0;
  int flush_left;
  int cnt;
  logic [9:0] exp_ctrl;

  // Drive inputs and compute the expected control word.
  task automatic apply(input logic r, input logic e,
                       input logic m, input logic b,
                       input logic l, input logic u);
    rst = r; ex = e; mr = m; rd = b; lsu = l; lu = u;
    if (r) begin
      flush_left = FC;
      cnt = 0;
    end
    if (r)                   exp_ctrl = 10'b0_00_01_01_01_1;
    else if (flush_left > 0) exp_ctrl = 10'b1_00_01_01_01_1;
    else if (e)              exp_ctrl = 10'b1_10_01_01_01_0;
    else if (m)              exp_ctrl = 10'b1_11_01_01_01_0;
    else if (b)              exp_ctrl = 10'b1_01_01_01_01_0;
    else if (l)              exp_ctrl = 10'b0_00_00_00_00_0;
    else if (u)              exp_ctrl = 10'b0_00_00_01_10_0;
    else                     exp_ctrl = 10'b1_00_10_10_10_0;
    #1;
  endtask

  // Clock edge: advance the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      flush_left = FC;
      cnt = 0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (ex | mr | rd) begin
      flush_left = FC;
    end else if (lsu | lu) begin
      cnt = (cnt < SAT) ? cnt + 1 : SAT;
    end
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < FC; i++) tick();
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 + FC + 2; i++) begin
      if (i >= 2) apply(0, 0, 0, 0, 0, 0);
      checks++;
      if (ctrl !== exp_ctrl || stall_count !== CW'(cnt)) begin
        errors++;
        $display("FAIL reset c%0d ctrl=%b cnt=%0d want %b %0d",
                 i, ctrl, stall_count, exp_ctrl, cnt);
      end
      tick();
    end
    checks++;
    if (flushing !== 1'b0 || pc_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_run flushing=%b sel=%0d want 0 0",
               flushing, pc_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (ctrl !== 10'b0_00_00_01_10_0 || stall_count !== 4'd0) begin
      errors++;
      $display("FAIL load_use ctrl=%b cnt=%0d want %b 0",
               ctrl, stall_count, 10'b0_00_00_01_10_0);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_count !== 4'd1 || ctrl !== exp_ctrl) begin
      errors++;
      $display("FAIL load_use_cnt cnt=%0d ctrl=%b want 1 %b",
               stall_count, ctrl, exp_ctrl);
    end
    tick();
  endtask

  task automatic test_lsu_hold();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, i < 3, i < 4);
      checks++;
      if (ctrl !== exp_ctrl || stall_count !== CW'(cnt)) begin
        errors++;
        $display("FAIL lsu_hold c%0d ctrl=%b cnt=%0d want %b %0d",
                 i, ctrl, stall_count, exp_ctrl, cnt);
      end
      if (i == 3) begin
        checks++;
        if (stall_count !== 4'd3) begin
          errors++;
          $display("FAIL lsu_cnt3 cnt=%0d want 3", stall_count);
        end
      end
      tick();
    end
    checks++;
    if (stall_count !== 4'd4) begin
      errors++;
      $display("FAIL lsu_cnt4 cnt=%0d want 4", stall_count);
    end
  endtask

  task automatic test_exception_redirect();
    do_reset();
    for (int i = 0; i < FC + 3; i++) begin
      if (i == 0) apply(0, 1, 0, 1, 1, 0);
      else        apply(0, 0, 0, 1, 0, 0);
      if (i == FC + 1) apply(0, 0, 0, 0, 0, 0);
      checks++;
      if (ctrl !== exp_ctrl || stall_count !== CW'(cnt)) begin
        errors++;
        $display("FAIL exc_redir c%0d ctrl=%b cnt=%0d want %b %0d",
                 i, ctrl, stall_count, exp_ctrl, cnt);
      end
      tick();
    end
  endtask

  task automatic test_mret_flush();
    apply(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < FC; i++) begin
      apply(0, 0, 1, 0, 0, 0);
      checks++;
      if (pc_sel !== 2'd0 || ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL mret_flush c%0d sel=%0d ctrl=%b want 0 %b",
                 i, pc_sel, ctrl, exp_ctrl);
      end
      tick();
    end
    apply(0, 0, 1, 0, 0, 0);
    checks++;
    if (pc_sel !== 2'd3 || ctrl !== exp_ctrl) begin
      errors++;
      $display("FAIL mret_run sel=%0d ctrl=%b want 3 %b",
               pc_sel, ctrl, exp_ctrl);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 0, 1, 0);
      tick();
    end
    checks++;
    if (stall_count !== 4'd15) begin
      errors++;
      $display("FAIL saturate cnt=%0d want 15", stall_count);
    end
    // asynchronous reset mid-stall, checked before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall_count !== 4'd0 || flushing !== 1'b1) begin
      errors++;
      $display("FAIL async_rst cnt=%0d fl=%b want 0 1",
               stall_count, flushing);
    end
    flush_left = FC;
    cnt = 0;
    tick();
  endtask

  task automatic test_random();
    logic r, e, m, b, l, u;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 11) == 0);
      m = ($urandom_range(0, 11) == 0);
      b = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 3) == 0);
      apply(r, e, m, b, l, u);
      checks++;
      if (ctrl !== exp_ctrl || stall_count !== CW'(cnt)) begin
        errors++;
        $display("FAIL random c%0d ctrl=%b cnt=%0d want %b %0d",
                 i, ctrl, stall_count, exp_ctrl, cnt);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; lu = 0; lsu = 0; rd = 0; ex = 0; mr = 0;
    flush_left = FC;
    cnt = 0;
    exp_ctrl = '0;
    test_reset();
    test_load_use();
    test_lsu_hold();
    test_exception_redirect();
    test_mret_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mirfak_pipeline_ctrl.md
Name: mirfak_pipeline_ctrl

Overview:
Central pipeline sequencer for the Mirfak core. Drives the enable/clear pairs of the IF/ID, ID/EX and EX/WB pipeline registers and selects the PC source. Resolves load-use hazards, LSU wait states, branch/jump redirects, traps and mret through a small state machine. Also keeps a saturating stall-cycle counter for the performance CSRs.

Parameters:
FLUSH_CYCLES, 1, extra cycles all stages stay cleared after a redirect (range 1..15)
STALL_CNT_W, 32, width of the stall-cycle counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset, asynchronous, active-high
id_load_use_i  in  1  ID instruction depends on a load currently in EX
wb_lsu_busy_i  in  1  LSU transaction in WB not yet acknowledged
wb_redirect_i  in  1  branch/jump taken, resolved in WB
wb_exception_i  in  1  valid, non-bubble exception in WB
wb_mret_i  in  1  mret retiring in WB
pc_enable_o  out  1  PC register update enable
pc_sel_o  out  2  0=PC+4, 1=branch target, 2=mtvec, 3=mepc
ifid_enable_o  out  1  IF/ID register enable
ifid_clear_o  out  1  IF/ID register clear
idex_enable_o  out  1  ID/EX register enable
idex_clear_o  out  1  ID/EX register clear
exwb_enable_o  out  1  EX/WB register enable
exwb_clear_o  out  1  EX/WB register clear
flushing_o  out  1  high while in FLUSH state
stall_count_o  out  STALL_CNT_W  number of cycles with pc_enable_o low in RUN

Behaviour:
- Two states: RUN, FLUSH. Reset forces FLUSH with flush counter = FLUSH_CYCLES and stall_count_o = 0.
- Outputs are combinational from the state and inputs. All state and counters are registered.
- While rst_i is high: every clear = 1, every enable = 0, pc_enable_o = 0, pc_sel_o = 0, flushing_o = 1.
- In RUN, events are prioritised from highest to lowest: exception > mret > redirect > lsu_busy > load_use > normal.
- Exception, mret or redirect (all in the same cycle):
  - pc_enable_o = 1.
  - pc_sel_o = 2, 3 or 1 respectively.
  - ifid_clear_o, idex_clear_o and exwb_clear_o = 1.
  - Next state is FLUSH, counter loaded with FLUSH_CYCLES.
- lsu_busy: every enable = 0, every clear = 0, pc_enable_o = 0. The whole pipe holds.
- load_use:
  - pc_enable_o = 0, ifid_enable_o = 0.
  - idex_clear_o = 1, which inserts a bubble.
  - exwb_enable_o = 1.
- Normal: every enable = 1, every clear = 0, pc_sel_o = 0.
- Clear has priority over enable. An enable is never asserted together with its clear.
- FLUSH state:
  - ifid_clear_o, idex_clear_o and exwb_clear_o = 1.
  - pc_enable_o = 1 and pc_sel_o = 0, so fetch refills from the new PC.
  - The counter decrements each cycle. When it is 1, next state is RUN.
- wb_* inputs are ignored in FLUSH, because WB holds only bubbles.
- FLUSH duration: exactly FLUSH_CYCLES cycles after the redirect cycle. On reset release, exactly FLUSH_CYCLES cycles.
- stall_count_o:
  - Increments by 1 in each RUN cycle where pc_enable_o = 0 (lsu_busy or load_use).
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Simultaneous exception and lsu_busy: the exception wins. The LSU is responsible for aborting its transaction.
- Reset asserted mid-FLUSH or mid-stall: immediate return to the reset condition, with no partial counter retained.

Test Plan:
- Reset released with FLUSH_CYCLES=1 and no events -> one cycle with all clears = 1 and flushing_o = 1, then RUN with all enables = 1 and pc_sel_o = 0; stall_count_o = 0.
- load_use pulsed for 1 cycle in RUN -> that cycle: pc_enable_o = 0, ifid_enable_o = 0, idex_clear_o = 1, exwb_enable_o = 1; stall_count_o 0 -> 1.
- wb_lsu_busy_i held for 3 cycles with load_use also high -> all enables and clears = 0 for 3 cycles; stall_count_o = 3; the next cycle resolves load_use (stall_count_o = 4).
- wb_exception_i and wb_redirect_i in the same cycle, FLUSH_CYCLES=2 -> pc_sel_o = 2, all clears = 1, then 2 FLUSH cycles with pc_sel_o = 0, then RUN.
- wb_mret_i during FLUSH -> ignored (pc_sel_o stays 0); a later wb_mret_i in RUN -> pc_sel_o = 3.
- STALL_CNT_W=4 with lsu_busy held for 20 cycles -> stall_count_o saturates at 15; reset asserted mid-stall -> 0 and flushing_o = 1 immediately.
